// File: rtl/shift_reg_bank.sv
// Multi-lane shift register bank: UPLOAD/LOAD/WRITE/READ on all lanes at once plus a skewed DRAIN.
// Optional CLEAR command is enabled by defining SHIFT_REG_BANK_CLEAR_EN.
module shift_reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int LANES      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [2:0]                          ctrl_code,
  input  logic [LANES*LENGTH*DATA_WIDTH-1:0]  data_in,
  input  logic [LANES*DATA_WIDTH-1:0]         data_write,
  output logic [LANES*LENGTH*DATA_WIDTH-1:0]  data_out,
  output logic [LANES*DATA_WIDTH-1:0]         data_read,
  output logic                                read_valid
);

  localparam int unsigned N  = LENGTH + LANES - 1;
  localparam int          SW = $clog2(LENGTH + LANES);

  typedef enum logic {IDLE, DRAIN} state_t;
  typedef enum logic [2:0] {
    OP_UPLOAD = 3'd0,
    OP_LOAD   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_DRAIN  = 3'd4,
    OP_CLEAR  = 3'd5,
    OP_NOP    = 3'd6
  } op_t;

  state_t  state;
  logic [SW-1:0] step;
  logic [SW-1:0] step_nxt;
  logic [SW-1:0] wave_step;

  // Word 0 of each lane sits in the least significant slot, matching the flat port packing.
  logic [LANES-1:0][LENGTH-1:0][DATA_WIDTH-1:0] mem;
  logic [LANES-1:0][LENGTH-1:0][DATA_WIDTH-1:0] shifted;
  logic [LANES-1:0][LENGTH-1:0][DATA_WIDTH-1:0] rotated;
  logic [LANES-1:0][DATA_WIDTH-1:0]             wr_word;
  logic [LANES-1:0][DATA_WIDTH-1:0]             heads;
  logic [LANES-1:0][DATA_WIDTH-1:0]             wave;

  assign cmd_ready = (state == IDLE);
  assign wr_word   = data_write;
  assign step_nxt  = step + 1'b1;
  // Step 0 is produced on the accept edge; each DRAIN edge produces the following step.
  assign wave_step = (state == DRAIN) ? step_nxt : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LENGTH:0][DATA_WIDTH-1:0] tap;

    assign shifted[i] = {wr_word[i], mem[i][LENGTH-1:1]};
    assign rotated[i] = {mem[i][0], mem[i][LENGTH-1:1]};
    assign heads[i]   = mem[i][0];
    assign tap[0]     = '0;

    // Lane i shows word (t - i) at step t; at most one word matches, otherwise zero.
    for (genvar j = 0; j < LENGTH; j++) begin : g_word
      assign tap[j+1] = (wave_step == SW'(i + j)) ? mem[i][j] : tap[j];
    end

    assign wave[i] = tap[LENGTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem        <= '0;
      data_out   <= '0;
      data_read  <= '0;
      read_valid <= 1'b0;
      state      <= IDLE;
      step       <= '0;
    end else begin
      read_valid <= 1'b0;
      if (state == DRAIN) begin
        data_read  <= wave;
        read_valid <= 1'b1;
        step       <= step_nxt;
        if (step_nxt == SW'(N - 1)) state <= IDLE;
      end else if (cmd_valid) begin
        case (op_t'(ctrl_code))
          OP_UPLOAD: data_out <= mem;
          OP_LOAD:   mem <= data_in;
          OP_WRITE:  mem <= shifted;
          OP_READ: begin
            mem        <= rotated;
            data_read  <= heads;
            read_valid <= 1'b1;
          end
          OP_DRAIN: begin
            data_read  <= wave;
            read_valid <= 1'b1;
            step       <= '0;
            if (N > 1) state <= DRAIN;
          end
`ifdef SHIFT_REG_BANK_CLEAR_EN
          OP_CLEAR:  mem <= '0;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_bank.sv
// Scoreboard bench for shift_reg_bank: stimulus queues expected words, a monitor compares
// data_read on read_valid and data_out one cycle after each accepted UPLOAD.
module tb_shift_reg_bank;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int LN  = 4;

  localparam logic [2:0] C_UPLOAD = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_WRITE  = 3'd2;
  localparam logic [2:0] C_READ   = 3'd3;
  localparam logic [2:0] C_DRAIN  = 3'd4;
  localparam logic [2:0] C_CLEAR  = 3'd5;
  localparam logic [2:0] C_NOP    = 3'd6;

  // lane i word j = 0x10*i + j ; lane 3 word 3 in the top byte
  localparam logic [127:0] LOAD_IMG = 128'h33323130_23222120_13121110_03020100;
  // after WRITE with data_write[i] = 0xA0+i
  localparam logic [127:0] WR_IMG   = 128'hA3333231_A2232221_A1131211_A0030201;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [2:0]             ctrl_code = 3'd0;
  logic [LN*LEN*DW-1:0]   data_in = '0;
  logic [LN*DW-1:0]       data_write = '0;
  logic [LN*LEN*DW-1:0]   data_out;
  logic [LN*DW-1:0]       data_read;
  logic                   read_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int up_req   = 0;
  int up_done  = 0;

  typedef struct {
    string        tag;
    logic [127:0] v;
  } exp_t;

  exp_t rd_q[$];
  exp_t up_q[$];
  exp_t mon_e;

  shift_reg_bank #(.DATA_WIDTH(DW), .LENGTH(LEN), .LANES(LN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ctrl_code  (ctrl_code),
    .data_in    (data_in),
    .data_write (data_write),
    .data_out   (data_out),
    .data_read  (data_read),
    .read_valid (read_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] v);
    rd_q.push_back('{tag, 128'(v)});
  endtask

  task automatic expect_up(input string tag, input logic [127:0] v);
    up_q.push_back('{tag, v});
  endtask

  // Caller is aligned to a negedge; the command is held for exactly one rising edge.
  task automatic issue(input logic [2:0] code);
    cmd_valid = 1'b1;
    ctrl_code = code;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  always @(posedge clk)
    if (!reset && cmd_valid && cmd_ready && ctrl_code == C_UPLOAD) up_req++;

  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("read_valid_unexpected", 128'(read_valid), 128'd0);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.tag, 128'(data_read), mon_e.v);
      end
    end
    if (up_done != up_req) begin
      up_done++;
      if (up_q.size() == 0) begin
        check("upload_unexpected", 128'(up_q.size()), 128'd1);
      end else begin
        mon_e = up_q.pop_front();
        check(mon_e.tag, data_out, mon_e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int lows;
    int rvs;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_read_valid", 128'(read_valid), 128'd0);
    check("reset_cmd_ready",  128'(cmd_ready),  128'd1);
    check("reset_data_out",   data_out,         128'd0);
    check("reset_data_read",  128'(data_read),  128'd0);

    expect_up("upload_after_reset", 128'd0);
    issue(C_UPLOAD);

    data_in = LOAD_IMG;
    issue(C_LOAD);
    expect_up("upload_load", LOAD_IMG);
    issue(C_UPLOAD);

    expect_rd("read0", 32'h30201000);
    expect_rd("read1", 32'h31211101);
    expect_rd("read2", 32'h32221202);
    expect_rd("read3", 32'h33231303);
    repeat (4) issue(C_READ);
    expect_up("upload_after_rotate", LOAD_IMG);
    issue(C_UPLOAD);
    issue(C_NOP);

    data_write = 32'hA3A2A1A0;
    issue(C_WRITE);
    expect_up("upload_write", WR_IMG);
    issue(C_UPLOAD);

    issue(C_LOAD);
    expect_rd("drain0", 32'h00000000);
    expect_rd("drain1", 32'h00001001);
    expect_rd("drain2", 32'h00201102);
    expect_rd("drain3", 32'h30211203);
    expect_rd("drain4", 32'h31221300);
    expect_rd("drain5", 32'h32230000);
    expect_rd("drain6", 32'h33000000);
    cmd_valid = 1'b1;
    ctrl_code = C_DRAIN;
    @(negedge clk);
    // A LOAD of all ones is held while the block is busy and must be ignored.
    ctrl_code = C_LOAD;
    data_in   = '1;
    lows = 0;
    rvs  = 0;
    for (int k = 0; k < 12; k++) begin
      if (cmd_ready == 1'b0) lows++;
      else cmd_valid = 1'b0;
      if (read_valid == 1'b1) rvs++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("drain_ready_low_cycles", 128'(lows), 128'd6);
    check("drain_read_valid_cycles", 128'(rvs), 128'd7);
    data_in = LOAD_IMG;
    expect_up("upload_after_drain", LOAD_IMG);
    issue(C_UPLOAD);

    expect_rd("abort_drain0", 32'h00000000);
    expect_rd("abort_drain1", 32'h00001001);
    cmd_valid = 1'b1;
    ctrl_code = C_DRAIN;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    ctrl_code = C_LOAD;
    data_in   = '1;
    @(negedge clk);
    check("abort_read_valid", 128'(read_valid), 128'd0);
    check("abort_data_read",  128'(data_read),  128'd0);
    check("abort_cmd_ready",  128'(cmd_ready),  128'd1);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    data_in   = LOAD_IMG;
    expect_up("upload_after_abort", 128'd0);
    issue(C_UPLOAD);

    issue(C_LOAD);
    issue(C_CLEAR);
`ifdef SHIFT_REG_BANK_CLEAR_EN
    expect_up("upload_after_clear", 128'd0);
`else
    expect_up("upload_after_clear", LOAD_IMG);
`endif
    issue(C_UPLOAD);

    repeat (3) @(negedge clk);
    check("read_queue_drained",   128'(rd_q.size()), 128'd0);
    check("upload_queue_drained", 128'(up_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
